// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel frame request in, idle-high bit-serial frame out.
// Frame: start 0, port (MSB first), length (MSB first), L payload bits
// (MSB first), then a single guard 1 during which frameDone pulses.
module serial_frame_tx #(
   parameter int PORT_W = 2,
   parameter int LEN_W  = 4,
   parameter int DATA_W = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              txValid,
   input  logic [PORT_W-1:0] txPort,
   input  logic [LEN_W-1:0]  txLen,
   input  logic [DATA_W-1:0] txData,
   output logic              txReady,
   output logic              busy,
   output logic              serOut,
   output logic              frameDone
);

   // The shared bit counter must cover both header fields and the payload.
   localparam int CNT_W  = (PORT_W > LEN_W) ? PORT_W : LEN_W;
   localparam int PIDX_W = (PORT_W > 1) ? $clog2(PORT_W) : 1;
   localparam int LIDX_W = (LEN_W > 1) ? $clog2(LEN_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_PORT,
      S_LEN,
      S_DATA,
      S_GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [PORT_W-1:0] port_q, port_d;
   logic [LEN_W-1:0]  len_q, len_d;
   // One spare zero bit on top so a LEN_W-bit index always lands in range.
   logic [DATA_W:0]   data_q, data_d;
   logic              ser_q, ser_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;

   logic              accept;
   logic [CNT_W-1:0]  cnt_dec;
   logic [LEN_W-1:0]  len_dec;

   assign txReady   = (state_q == S_IDLE) || (state_q == S_GAP);
   assign accept    = txValid && txReady;
   assign busy      = busy_q;
   assign serOut    = ser_q;
   assign frameDone = done_q;

   // Next-state, next-bit and capture logic; the bit for a state is
   // selected one cycle early so serOut comes straight from a flop.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      port_d  = port_q;
      len_d   = len_q;
      data_d  = data_q;
      ser_d   = ser_q;
      done_d  = 1'b0;
      cnt_dec = cnt_q - CNT_W'(1);
      len_dec = len_q - LEN_W'(1);

      if (accept) begin
         port_d = txPort;
         len_d  = txLen;
         data_d = {1'b0, txData};
      end

      case (state_q)
         S_IDLE: begin
            ser_d = 1'b1;
            if (accept) begin
               state_d = S_START;
               ser_d   = 1'b0;
            end
         end
         S_START: begin
            state_d = S_PORT;
            cnt_d   = CNT_W'(PORT_W - 1);
            ser_d   = port_q[PORT_W-1];
         end
         S_PORT: begin
            if (cnt_q == '0) begin
               state_d = S_LEN;
               cnt_d   = CNT_W'(LEN_W - 1);
               ser_d   = len_q[LEN_W-1];
            end else begin
               cnt_d = cnt_dec;
               ser_d = port_q[cnt_dec[PIDX_W-1:0]];
            end
         end
         S_LEN: begin
            if (cnt_q == '0) begin
               if (len_q != '0) begin
                  state_d = S_DATA;
                  cnt_d   = CNT_W'(len_dec);
                  ser_d   = data_q[len_dec];
               end else begin
                  state_d = S_GAP;
                  ser_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_dec;
               ser_d = len_q[cnt_dec[LIDX_W-1:0]];
            end
         end
         S_DATA: begin
            if (cnt_q == '0) begin
               state_d = S_GAP;
               ser_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_dec;
               ser_d = data_q[cnt_dec[LEN_W-1:0]];
            end
         end
         S_GAP: begin
            ser_d = 1'b1;
            if (accept) begin
               state_d = S_START;
               ser_d   = 1'b0;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            ser_d   = 1'b1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State and output registers; reset forces the line high immediately.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         port_q  <= '0;
         len_q   <= '0;
         data_q  <= '0;
         ser_q   <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         port_q  <= port_d;
         len_q   <= len_d;
         data_q  <= data_d;
         ser_q   <= ser_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed frame vectors with hand-computed line bits,
// back-to-back, mid-frame reset and a bench-side receiver for loopback.
module tb_serial_frame_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        txValid = 1'b0;
   logic [1:0]  txPort = '0;
   logic [3:0]  txLen = '0;
   logic [14:0] txData = '0;
   logic        txReady, busy, serOut, frameDone;

   int checks = 0;
   int errors = 0;

   serial_frame_tx #(.PORT_W(2), .LEN_W(4), .DATA_W(15)) dut (
      .clk(clk), .rst(rst), .txValid(txValid), .txPort(txPort),
      .txLen(txLen), .txData(txData), .txReady(txReady), .busy(busy),
      .serOut(serOut), .frameDone(frameDone)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  port;
      logic [3:0]  len;
      logic [14:0] data;
      logic [21:0] exp;   // expected line bits, first bit at exp[n-1]
      int          n;     // bits before the guard bit
      string       name;
   } vec_t;

   vec_t vecs[5];

   typedef struct {
      logic [1:0]  port;
      logic [3:0]  len;
      logic [14:0] data;
      logic        guard;
   } rx_t;

   rx_t  rxq[$];
   logic rx_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called just after the accepting edge: checks every bit and the guard.
   task automatic frame_checks(input logic [21:0] exp, input int n, input string name);
      for (int i = n - 1; i >= 0; i--) begin
         @(negedge clk);
         chk({name, "_bit"}, 32'(serOut), 32'(exp[i]));
         chk({name, "_ready"}, 32'(txReady), 0);
         chk({name, "_busy"}, 32'(busy), 1);
         chk({name, "_done"}, 32'(frameDone), 0);
      end
      @(negedge clk);
      chk({name, "_guard"}, 32'(serOut), 1);
      chk({name, "_donepulse"}, 32'(frameDone), 1);
      chk({name, "_gapbusy"}, 32'(busy), 1);
      chk({name, "_gapready"}, 32'(txReady), 1);
   endtask

   task automatic idle_checks(input string name);
      @(negedge clk);
      chk({name, "_idle_ser"}, 32'(serOut), 1);
      chk({name, "_idle_done"}, 32'(frameDone), 0);
      chk({name, "_idle_busy"}, 32'(busy), 0);
      chk({name, "_idle_ready"}, 32'(txReady), 1);
   endtask

   // Present one request in IDLE, then scramble inputs after acceptance.
   task automatic drive_accept(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
      @(negedge clk);
      txPort  = p;
      txLen   = l;
      txData  = d;
      txValid = 1'b1;
      @(posedge clk);
      #1;
      txValid = 1'b0;
      txPort  = ~p;
      txLen   = ~l;
      txData  = ~d;
   endtask

   // Bench-side receiver decoding the line for the loopback test.
   initial begin
      int         rx_st;
      int         rx_cnt;
      logic [1:0] rp;
      logic [3:0] rl;
      logic [14:0] rd;
      rx_st = 0; rx_cnt = 0; rp = '0; rl = '0; rd = '0;
      forever begin
         @(negedge clk);
         if (!rx_en) begin
            rx_st = 0;
         end else begin
            case (rx_st)
               0: if (serOut == 1'b0) begin
                     rx_st = 1; rx_cnt = 0; rp = '0; rl = '0; rd = '0;
                  end
               1: begin
                     rp = {rp[0], serOut};
                     rx_cnt++;
                     if (rx_cnt == 2) begin rx_st = 2; rx_cnt = 0; end
                  end
               2: begin
                     rl = {rl[2:0], serOut};
                     rx_cnt++;
                     if (rx_cnt == 4) begin
                        rx_cnt = 0;
                        rx_st = (rl == 4'd0) ? 4 : 3;
                     end
                  end
               3: begin
                     rd = {rd[13:0], serOut};
                     rx_cnt++;
                     if (rx_cnt == int'(rl)) rx_st = 4;
                  end
               default: begin
                     rxq.push_back('{rp, rl, rd, serOut});
                     rx_st = 0;
                  end
            endcase
         end
      end
   end

   initial begin
      logic [1:0]  lb_port [4];
      logic [3:0]  lb_len  [4];
      logic [14:0] lb_data [4];
      logic [14:0] mask;

      vecs[0] = '{2'b10, 4'd5,  15'h7FF6, 22'b0000000000_010_0101_10110,   12, "basic"};
      vecs[1] = '{2'b01, 4'd0,  15'h7FFF, 22'b000000000000000_001_0000,    7,  "zerolen"};
      vecs[2] = '{2'b11, 4'd1,  15'h0001, 22'b00000000000000_011_0001_1,   8,  "len1"};
      vecs[3] = '{2'b00, 4'd7,  15'h7FD3, 22'b00000000_000_0111_1010011,   14, "len7"};
      vecs[4] = '{2'b11, 4'd15, 15'h4001, 22'b0_11_1111_100000000000001,   22, "len15"};

      // Reset held with a pending request: no response.
      txValid = 1'b1;
      txPort  = vecs[0].port;
      txLen   = vecs[0].len;
      txData  = vecs[0].data;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_ser", 32'(serOut), 1);
         chk("rst_ready", 32'(txReady), 1);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_done", 32'(frameDone), 0);
      end
      rst = 1'b1;
      @(posedge clk);
      #1;
      txValid = 1'b0;
      $display("frame reset_release port=%0d len=%0d", vecs[0].port, vecs[0].len);
      frame_checks(vecs[0].exp, vecs[0].n, "rstrel");
      idle_checks("rstrel");

      // Table-driven single frames.
      for (int v = 0; v < 5; v++) begin
         drive_accept(vecs[v].port, vecs[v].len, vecs[v].data);
         $display("frame %s port=%0d len=%0d data=%0h", vecs[v].name, vecs[v].port, vecs[v].len, vecs[v].data);
         frame_checks(vecs[v].exp, vecs[v].n, vecs[v].name);
         idle_checks(vecs[v].name);
      end

      // Back-to-back with txValid held; second request waits out frame one.
      @(negedge clk);
      txPort = 2'b01; txLen = 4'd15; txData = 15'h7FFF; txValid = 1'b1;
      @(posedge clk);
      #1;
      txPort = 2'b10; txLen = 4'd3; txData = 15'h7FF9;
      $display("frame b2b_a port=1 len=15 data=7fff");
      frame_checks(22'b0_01_1111_111111111111111, 22, "b2b_a");
      @(posedge clk);
      #1;
      txValid = 1'b0;
      txPort = 2'b00; txLen = 4'd9; txData = 15'h0000;
      $display("frame b2b_b port=2 len=3 data=1");
      frame_checks(22'b000000000000_010_0011_001, 10, "b2b_b");
      idle_checks("b2b");

      // Asynchronous reset in the middle of the payload.
      drive_accept(2'b11, 4'd15, 15'h0000);
      $display("frame midreset port=3 len=15 data=0 (abandoned)");
      repeat (9) @(negedge clk);
      chk("mid_predata", 32'(serOut), 0);
      #2;
      rst = 1'b0;
      #1;
      chk("mid_async_ser", 32'(serOut), 1);
      chk("mid_async_busy", 32'(busy), 0);
      chk("mid_async_ready", 32'(txReady), 1);
      chk("mid_async_done", 32'(frameDone), 0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("mid_hold_ser", 32'(serOut), 1);
         chk("mid_hold_done", 32'(frameDone), 0);
      end
      rst = 1'b1;
      drive_accept(vecs[3].port, vecs[3].len, vecs[3].data);
      $display("frame after_reset port=%0d len=%0d data=%0h", vecs[3].port, vecs[3].len, vecs[3].data);
      frame_checks(vecs[3].exp, vecs[3].n, "postrst");
      idle_checks("postrst");

      // Loopback through the bench receiver.
      lb_port = '{2'd0, 2'd1, 2'd2, 2'd3};
      lb_len  = '{4'd1, 4'd7, 4'd15, 4'd0};
      lb_data = '{15'h7FFF, 15'h0055, 15'h2A5C, 15'h7FFF};
      rx_en = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         int w;
         drive_accept(lb_port[k], lb_len[k], lb_data[k]);
         $display("frame loopback%0d port=%0d len=%0d data=%0h", k, lb_port[k], lb_len[k], lb_data[k]);
         w = 0;
         while (frameDone !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
         end
         chk("lb_timeout", 32'(w < 40), 1);
      end
      repeat (2) @(negedge clk);
      rx_en = 1'b0;
      chk("lb_count", 32'(rxq.size()), 4);
      for (int k = 0; k < 4 && k < rxq.size(); k++) begin
         mask = 15'((32'd1 << lb_len[k]) - 1);
         chk("lb_port", 32'(rxq[k].port), 32'(lb_port[k]));
         chk("lb_len", 32'(rxq[k].len), 32'(lb_len[k]));
         chk("lb_data", 32'(rxq[k].data), 32'(lb_data[k] & mask));
         chk("lb_guard", 32'(rxq[k].guard), 1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the run always terminates.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
